// File: rtl/field_pack_accum_pkg.sv
// Shared types and helpers for the field packer: FSM states, default
// geometry and the field-slot bit mapping used by every slot writer.
package field_pack_pkg;

  localparam int DEF_NUM_FIELDS = 4;
  localparam int DEF_FIELD_W    = 4;
  localparam bit DEF_MSB_FIRST  = 1'b1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } field_pack_state_e;

  // LSB of field k's slice; MSB-first places field 0 in the top slice,
  // matching packed-struct declaration order.
  function automatic int slot_lo(input int k, input int num_fields,
                                 input int field_w, input bit msb_first);
    if (msb_first) begin
      return (num_fields - 1 - k) * field_w;
    end
    return k * field_w;
  endfunction

  function automatic int idx_width(input int num_fields);
    return (num_fields > 1) ? $clog2(num_fields) : 1;
  endfunction

endpackage

// File: rtl/field_pack_accum_if.sv
// Beat-in / word-out bus of the field packer.
// Handshake: a transfer happens on a rising edge where valid && ready;
// the sender holds payload stable while valid is high and not yet accepted.
interface field_pack_accum_if
  import field_pack_pkg::*;
#(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int FIELD_W    = DEF_FIELD_W
);

  localparam int WORD_W = NUM_FIELDS * FIELD_W;
  localparam int CNT_W  = $clog2(NUM_FIELDS + 1);

  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] in_data;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;
  logic [CNT_W-1:0]   out_count;
  logic               out_short;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_short
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_short
  );

endinterface

// File: rtl/field_pack_accum_slot_write.sv
// Combinational slot replace: returns word_i with field idx_i set to data_i.
// Shared by the in-place fill path and the restart-from-zero path.
module field_slot_write
  import field_pack_pkg::*;
#(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int FIELD_W    = DEF_FIELD_W,
  parameter bit MSB_FIRST  = DEF_MSB_FIRST,
  parameter int IDX_W      = idx_width(NUM_FIELDS)
) (
  input  logic [NUM_FIELDS*FIELD_W-1:0] word_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [FIELD_W-1:0]            data_i,
  output logic [NUM_FIELDS*FIELD_W-1:0] word_o
);

  localparam int WORD_W = NUM_FIELDS * FIELD_W;
  localparam logic [WORD_W-1:0] FIELD_MASK = WORD_W'({FIELD_W{1'b1}});

  always_comb begin
    word_o = word_i;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (int'(idx_i) == k) begin
        word_o = (word_o & ~(FIELD_MASK << slot_lo(k, NUM_FIELDS, FIELD_W, MSB_FIRST)))
               | (WORD_W'(data_i) << slot_lo(k, NUM_FIELDS, FIELD_W, MSB_FIRST));
      end
    end
  end

endmodule

// File: rtl/field_pack_accum.sv
// Assembles NUM_FIELDS field beats into one packed word and holds it on the
// output port; supports early termination (zero-filled) and gapless restart.
module field_pack_accum
  import field_pack_pkg::*;
#(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int FIELD_W    = DEF_FIELD_W,
  parameter bit MSB_FIRST  = DEF_MSB_FIRST
) (
  input  logic               clk,
  input  logic               rst_n,
  field_pack_accum_if.slave  bus,
  output field_pack_state_e  state_o
);

  localparam int WORD_W = NUM_FIELDS * FIELD_W;
  localparam int IDX_W  = idx_width(NUM_FIELDS);
  localparam int CNT_W  = $clog2(NUM_FIELDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  field_pack_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              short_q, short_d;

  logic [WORD_W-1:0] fill_word;
  logic [WORD_W-1:0] restart_word;

  field_slot_write #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_W    (FIELD_W),
    .MSB_FIRST  (MSB_FIRST),
    .IDX_W      (IDX_W)
  ) u_fill_write (
    .word_i (word_q),
    .idx_i  (idx_q),
    .data_i (bus.in_data),
    .word_o (fill_word)
  );

  // A beat taken during handoff starts a fresh word, so build it from zero.
  field_slot_write #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_W    (FIELD_W),
    .MSB_FIRST  (MSB_FIRST),
    .IDX_W      (IDX_W)
  ) u_restart_write (
    .word_i ('0),
    .idx_i  ('0),
    .data_i (bus.in_data),
    .word_o (restart_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      count_q <= count_d;
      short_q <= short_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    count_d = count_q;
    short_d = short_q;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          word_d = fill_word;
          if ((idx_q == LAST_IDX) || bus.in_last) begin
            state_d = HOLD;
            count_d = CNT_W'(idx_q) + CNT_W'(1);
            short_d = bus.in_last && (idx_q != LAST_IDX);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            word_d = restart_word;
            if (bus.in_last || (NUM_FIELDS == 1)) begin
              state_d = HOLD;
              count_d = CNT_W'(1);
              short_d = (NUM_FIELDS > 1);
              idx_d   = '0;
            end else begin
              state_d = FILL;
              idx_d   = IDX_W'(1);
            end
          end else begin
            state_d = FILL;
            word_d  = '0;
            idx_d   = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
        idx_d   = '0;
        word_d  = '0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == FILL) || bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = word_q;
  assign bus.out_count = count_q;
  assign bus.out_short = short_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_field_pack_accum.sv
// Bench for field_pack_accum: directed scenarios plus random traffic against
// a beat-list reference model; two NUM_FIELDS=2 instances cover field order.
module tb_field_pack_accum;
  import field_pack_pkg::*;

  localparam int NF    = 4;
  localparam int FW    = 4;
  localparam int WW    = NF * FW;
  localparam int CW    = $clog2(NF + 1);
  localparam int EXP_W = WW + CW + 1;

  typedef struct packed {
    logic [FW-1:0] f0;
    logic [FW-1:0] f1;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  field_pack_accum_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) bus4 ();
  field_pack_accum_if #(.NUM_FIELDS(2), .FIELD_W(FW)) bus2m ();
  field_pack_accum_if #(.NUM_FIELDS(2), .FIELD_W(FW)) bus2l ();

  field_pack_state_e st4, st2m, st2l;

  field_pack_accum #(.NUM_FIELDS(NF), .FIELD_W(FW), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .state_o(st4));
  field_pack_accum #(.NUM_FIELDS(2), .FIELD_W(FW), .MSB_FIRST(1'b1)) dut2m (
    .clk(clk), .rst_n(rst_n), .bus(bus2m), .state_o(st2m));
  field_pack_accum #(.NUM_FIELDS(2), .FIELD_W(FW), .MSB_FIRST(1'b0)) dut2l (
    .clk(clk), .rst_n(rst_n), .bus(bus2l), .state_o(st2l));

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int valid_cycles = 0;
  logic [EXP_W-1:0] exp_q[$];
  int cur_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Field k of an n-field word sits k slices below the top; missing fields are zero.
  function automatic logic [WW-1:0] model_word();
    logic [WW-1:0] w;
    w = '0;
    foreach (cur_q[k]) w = (w << FW) | WW'(cur_q[k]);
    return w << ((NF - cur_q.size()) * FW);
  endfunction

  task automatic cycle();
    bit exp_valid, in_fire, out_fire;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    check("out_valid", 32'(bus4.out_valid), 32'(exp_valid));
    check("in_ready", 32'(bus4.in_ready), 32'(!exp_valid || bus4.out_ready));
    if (exp_valid) begin
      check("out_word", 32'({bus4.out_data, bus4.out_count, bus4.out_short}), 32'(exp_q[0]));
    end
    in_fire  = bus4.in_valid && (!exp_valid || bus4.out_ready);
    out_fire = exp_valid && bus4.out_ready;
    if (bus4.out_valid) valid_cycles++;
    @(posedge clk);
    if (out_fire) void'(exp_q.pop_front());
    if (in_fire) begin
      beats++;
      cur_q.push_back(int'(bus4.in_data));
      if (bus4.in_last || (cur_q.size() == NF)) begin
        exp_q.push_back({model_word(), CW'(cur_q.size()), bus4.in_last && (cur_q.size() < NF)});
        cur_q.delete();
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [FW-1:0] d, input bit l, input bit r);
    bus4.in_valid  = v;
    bus4.in_data   = d;
    bus4.in_last   = l;
    bus4.out_ready = r;
    cycle();
  endtask

  task automatic pair_set(input bit v, input logic [FW-1:0] d, input bit r);
    bus2m.in_valid = v;  bus2m.in_data = d;  bus2m.in_last = 1'b0;  bus2m.out_ready = r;
    bus2l.in_valid = v;  bus2l.in_data = d;  bus2l.in_last = 1'b0;  bus2l.out_ready = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus4.out_valid), 32'd0);
    check({tag, "_data"},  32'(bus4.out_data),  32'd0);
    check({tag, "_count"}, 32'(bus4.out_count), 32'd0);
    check({tag, "_short"}, 32'(bus4.out_short), 32'd0);
    check({tag, "_state"}, 32'(st4),            32'(FILL));
  endtask

  initial begin
    pair_t pv;
    int b0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0;  bus4.in_data = '0;  bus4.in_last = 1'b0;  bus4.out_ready = 1'b1;
    pair_set(1'b0, '0, 1'b1);

    #12;
    check_reset_outputs("rst");
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_pair_data", 32'(bus2m.out_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Field order on two-field words.
    pair_set(1'b1, 4'hA, 1'b1);  cycle();
    pair_set(1'b1, 4'h5, 1'b1);  cycle();
    pair_set(1'b0, 4'h0, 1'b0);  cycle();
    pv = bus2m.out_data;
    check("pair_m_valid", 32'(bus2m.out_valid), 32'd1);
    check("pair_m_data",  32'(bus2m.out_data),  32'hA5);
    check("pair_m_count", 32'(bus2m.out_count), 32'd2);
    check("pair_m_short", 32'(bus2m.out_short), 32'd0);
    check("pair_f0",      32'(pv.f0),           32'hA);
    check("pair_f1",      32'(pv.f1),           32'h5);
    check("pair_l_data",  32'(bus2l.out_data),  32'h5A);
    check("pair_l_state", 32'(st2l),            32'(HOLD));
    pair_set(1'b0, 4'h0, 1'b1);  cycle();
    check("pair_drain_valid", 32'(bus2m.out_valid), 32'd0);
    check("pair_drain_data",  32'(bus2l.out_data),  32'd0);

    // Early termination after two beats.
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    drive(1'b1, 4'h2, 1'b1, 1'b0);
    check("short_data",  32'(bus4.out_data),  32'h1200);
    check("short_count", 32'(bus4.out_count), 32'd2);
    check("short_flag",  32'(bus4.out_short), 32'd1);
    check("short_state", 32'(st4),            32'(HOLD));

    // Back-pressure, then handoff with a beat in the same cycle.
    repeat (5) drive(1'b1, 4'h7, 1'b0, 1'b0);
    b0 = beats;
    drive(1'b1, 4'h7, 1'b0, 1'b1);
    drive(1'b1, 4'h8, 1'b0, 1'b1);
    drive(1'b1, 4'h9, 1'b0, 1'b1);
    drive(1'b1, 4'hA, 1'b0, 1'b1);
    check("restart_beats", 32'(beats - b0), 32'd4);
    check("restart_data",  32'(bus4.out_data), 32'h789A);
    drive(1'b0, 4'h0, 1'b0, 1'b1);

    // Three back-to-back full words.
    b0 = beats;
    valid_cycles = 0;
    for (int i = 0; i < 12; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("b2b_beats", 32'(beats - b0), 32'd12);
    check("b2b_pulses", 32'(valid_cycles), 32'd3);

    // Asynchronous reset mid-word.
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    drive(1'b1, 4'h2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    cur_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    drive(1'b1, 4'h2, 1'b0, 1'b1);
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    drive(1'b1, 4'h4, 1'b0, 1'b1);
    check("post_rst_data",  32'(bus4.out_data),  32'h1234);
    check("post_rst_count", 32'(bus4.out_count), 32'd4);
    check("post_rst_short", 32'(bus4.out_short), 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b1);

    // Random traffic against the reference model.
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_pack_accum.md
Name: field_pack_accum

Overview:
- Sequential successor to the static two-field packed-struct assembly.
- Accepts a stream of NUM_FIELDS field beats over a valid/ready handshake and assembles them into one packed word, with a configurable field order.
- Supports early termination with zero-fill.
- Presents the assembled word on an output valid/ready port.
- Sits between narrow field producers and struct-typed consumers.

Parameters:
- NUM_FIELDS, 4, number of fields per packed word (>=2).
- FIELD_W, 4, width of each field in bits (>=1).
- MSB_FIRST, 1, 1: field 0 occupies the top slice (packed-struct declaration order); 0: field 0 occupies bits [FIELD_W-1:0].

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  field beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  FIELD_W  field value.
- in_last  input  1  beat is the final field of this word.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer accepts word.
- out_data  output  NUM_FIELDS*FIELD_W  assembled packed word.
- out_count  output  $clog2(NUM_FIELDS+1)  number of fields written (1..NUM_FIELDS).
- out_short  output  1  word terminated by in_last before NUM_FIELDS beats.

Behaviour:
- States: FILL, HOLD. Reset -> FILL.
- Reset values: idx=0, out_data=0, out_count=0, out_short=0, out_valid=0.
- in_ready=1 in FILL. In HOLD, in_ready=out_ready (pass-through restart).
- Slot mapping for field k:
  - MSB_FIRST=1: bits [(NUM_FIELDS-k)*FIELD_W-1 -: FIELD_W].
  - MSB_FIRST=0: bits [k*FIELD_W +: FIELD_W].
- FILL, beat accepted (in_valid & in_ready):
  - Write in_data to slot idx; idx++.
  - If idx==NUM_FIELDS-1 or in_last: go to HOLD next cycle; out_count=idx+1; out_short = in_last & (idx<NUM_FIELDS-1); idx=0.
  - Unwritten slots stay zero, because the word is cleared at each restart.
- in_last on the final slot: out_short=0; in_last is ignored beyond that point (no wrap).
- HOLD: out_valid=1; out_data, out_count and out_short remain stable until out_ready.
- HOLD, out_ready & !in_valid: -> FILL, word register cleared to 0, out_valid=0.
- HOLD, out_ready & in_valid (simultaneous):
  - Word handed off.
  - New word = zeros with in_data in slot 0; idx=1.
  - If in_last, or NUM_FIELDS rules would complete the word: stay in HOLD with the new word, out_count=1, out_short=(NUM_FIELDS>1).
  - Otherwise -> FILL.
- Latency: word valid the cycle after its final beat is accepted. Full throughput: one beat per cycle, including across word boundaries.
- Reset asserted mid-word: partial word discarded, all outputs return to reset values immediately (async).
- out_count, out_short and out_data are registered outputs; no combinational path from in_data to out_data.
- in_data and in_last are don't-care when in_valid=0.

Decomposition:
- Shared package field_pack_pkg:
  - function slot_lo(k, num_fields, field_w, msb_first) returning the slice LSB.
  - typedef enum logic {FILL, HOLD} field_pack_state_e.
  - localparam defaults for NUM_FIELDS and FIELD_W.
- One sub-module, field_slot_write: combinational; given word, idx and data, returns the word with that slot replaced. Reused for the normal write and the restart write.
- The packed struct type is declared locally in the benches (parameter-dependent), not in the package.

Test Plan:
- NUM_FIELDS=2, FIELD_W=4, MSB_FIRST=1; beats 0xA, 0x5 -> out_data=0xA5, out_count=2, out_short=0; struct view field0==0xA, field1==0x5.
- Same parameters with MSB_FIRST=0; beats 0xA, 0x5 -> out_data=0x5A.
- NUM_FIELDS=4, FIELD_W=4; beats 0x1, 0x2 with in_last on 2nd -> out_data=0x1200, out_count=2, out_short=1.
- out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0; then out_ready=1 with in_valid=1 and in_data=0x7 -> handoff; next word slot 0 = 0x7; 4-beat stream continues at one beat per cycle with no bubble.
- Back-to-back 3 words of 4 beats with out_ready held at 1 -> 12 beats in 12 cycles; each word correct; out_valid pulses once per word.
- rst_n low after 2 of 4 beats -> outputs zero asynchronously; after release, full 4-beat word 0x1,0x2,0x3,0x4 -> out_data=0x1234, no residue from the aborted word.
